// File: rtl/data_bus_uart_if.sv
// Core data-memory port as seen by the RAM/UART decoder.
// The core drives address, strobes and write data. The decoder returns registered read data.
interface data_bus_uart_if;
  logic [31:0] mem_addr;
  logic        mem_r_enable;
  logic        mem_w_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (output mem_addr, mem_r_enable, mem_w_enable, mem_wdata, input mem_rdata);
  modport slave  (input mem_addr, mem_r_enable, mem_w_enable, mem_wdata, output mem_rdata);
endinterface

// File: rtl/data_bus_uart.sv
// Data-bus decoder: word RAM plus a memory-mapped 8N1 UART transmitter with TX FIFO.
// Read data is registered (1-cycle latency) and holds between reads.
module data_bus_uart #(
  parameter int RAM_WORDS    = 1024,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic           clk,
  input  logic           reset_n,
  data_bus_uart_if.slave bus,
  output logic           uart_tx
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [31:0]   TXDATA_ADDR = 32'h1000_0000;
  localparam logic [31:0]   STATUS_ADDR = 32'h1000_0004;
  localparam logic [31:0]   RAM_BYTES   = 32'(RAM_WORDS * 4);
  localparam logic [BW-1:0] BAUD_LAST   = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH       = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [31:0]   ram  [RAM_WORDS];
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;

  state_t        state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shreg, shreg_n;
  logic          tx_n, pop;

  logic          hit_ram, hit_tx, hit_st;
  logic          fifo_empty, fifo_full, tx_busy, push_req, push_ok;
  logic [AW-1:0] widx;
  logic [31:0]   rdata_n;

  assign hit_ram    = bus.mem_addr < RAM_BYTES;
  assign hit_tx     = bus.mem_addr == TXDATA_ADDR;
  assign hit_st     = bus.mem_addr == STATUS_ADDR;
  assign widx       = bus.mem_addr[AW+1:2];
  assign fifo_empty = count == '0;
  assign fifo_full  = count == DEPTH;
  assign tx_busy    = state != IDLE;
  assign push_req   = bus.mem_w_enable && hit_tx;
  // A pop in the same cycle frees a slot, so a push onto a full FIFO still lands.
  assign push_ok    = push_req && (!fifo_full || pop);

  // Snapshot uses pre-edge state: old RAM word, STATUS before push/clear.
  always_comb begin
    rdata_n = '0;
    if (hit_ram)     rdata_n = ram[widx];
    else if (hit_st) rdata_n = {27'b0, overflow, tx_busy, fifo_empty, fifo_full, 1'b0};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              bus.mem_rdata <= '0;
    else if (bus.mem_r_enable) bus.mem_rdata <= rdata_n;
  end

  always_ff @(posedge clk) begin
    if (bus.mem_w_enable && hit_ram) ram[widx] <= bus.mem_wdata;
    if (push_ok)                     fifo[wr_ptr] <= bus.mem_wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_req && !push_ok)              overflow <= 1'b1;
      else if (bus.mem_r_enable && hit_st)   overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
      uart_tx <= tx_n;
    end
  end

  // tx_n is the line level for the next cycle; shreg[0] is always the bit on the wire in DATA.
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    shreg_n = shreg;
    tx_n    = uart_tx;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_n = fifo[rd_ptr];
          baud_n  = '0;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (baud == BAUD_LAST) begin
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = shreg[0];
          state_n = DATA;
        end else baud_n = baud + BW'(1);
      end
      DATA: begin
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            bit_n   = bit_idx + 3'd1;
            shreg_n = {1'b0, shreg[7:1]};
            tx_n    = shreg[1];
          end
        end else baud_n = baud + BW'(1);
      end
      STOP: begin
        if (baud == BAUD_LAST) begin
          baud_n  = '0;
          state_n = IDLE;
        end else baud_n = baud + BW'(1);
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_data_bus_uart.sv
// Self-checking bench for data_bus_uart: read-data and UART-byte scoreboards.
// A serial receiver model decodes uart_tx frames independently of the RTL.
module tb_data_bus_uart;
  localparam int CPB = 4;
  localparam logic [31:0] TXD = 32'h1000_0000;
  localparam logic [31:0] STA = 32'h1000_0004;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic uart_tx;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] exp_q[$];
  logic [8:0]  exp_tx_q[$];
  logic [8:0]  rx_q[$];
  logic [8:0]  rx_b;

  data_bus_uart_if bus();

  data_bus_uart #(.RAM_WORDS(1024), .FIFO_DEPTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  // Receiver: detect start, sample mid-bit, push {stop, byte}
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && uart_tx === 1'b0) begin
        repeat (CPB/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rx_b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        rx_b[8] = uart_tx;
        rx_q.push_back(rx_b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic bus_idle;
    bus.mem_addr = '0; bus.mem_wdata = '0;
    bus.mem_r_enable = 1'b0; bus.mem_w_enable = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus.mem_addr = a; bus.mem_wdata = d;
    bus.mem_w_enable = 1'b1; bus.mem_r_enable = 1'b0;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] got);
    bus.mem_addr = a; bus.mem_r_enable = 1'b1; bus.mem_w_enable = 1'b0;
    @(negedge clk);
    bus_idle();
    got = bus.mem_rdata;
  endtask

  task automatic test_reset;
    logic [31:0] got, e;
    bus_idle();
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.mem_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=%h", bus.mem_rdata, 32'h0); end
    checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", uart_tx); end
    reset_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(32'h04);
    bus_rd(STA, got); e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL reset_status got=%h exp=%h", got, e); end
  endtask

  task automatic test_ram;
    logic [31:0] got, e, d;
    logic [31:0] addrs[5];
    bus_wr(32'h10, 32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    bus_rd(32'h12, got); e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL ram_read got=%h exp=%h", got, e); end
    repeat (3) @(negedge clk);
    bus_wr(32'h20, 32'h1111_1111);
    checks++; if (bus.mem_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rdata_hold got=%h exp=%h", bus.mem_rdata, 32'hDEAD_BEEF); end
    addrs = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'hFFC};
    foreach (addrs[i]) begin
      d = $urandom();
      bus_wr(addrs[i], d);
      exp_q.push_back(d);
    end
    foreach (addrs[i]) begin
      bus_rd(addrs[i], got); e = exp_q.pop_front();
      checks++; if (got !== e) begin failures++; $display("FAIL ram_word%0d got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_unmapped;
    logic [31:0] got, e;
    bus_wr(32'h0, 32'h1234_5678);
    exp_q.push_back(32'h0);
    bus_rd(32'h2000_0000, got); e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL unmapped_read got=%h exp=%h", got, e); end
    bus_wr(32'h3000_0000, 32'hFFFF_FFFF);
    bus_wr(32'h0000_1000, 32'hBAD0_BAD0);
    bus_wr(32'h1000_0008, 32'h0000_00AA);
    exp_q.push_back(32'h1234_5678);
    bus_rd(32'h0, got); e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL unmapped_write_ram got=%h exp=%h", got, e); end
    exp_q.push_back(32'h0);
    bus_rd(TXD, got); e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL txdata_read got=%h exp=%h", got, e); end
    exp_q.push_back(32'h04);
    bus_rd(STA, got); e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL unmapped_status got=%h exp=%h", got, e); end
  endtask

  task automatic test_rw_same;
    logic [31:0] got, e;
    bus_wr(32'h40, 32'h1);
    bus.mem_addr = 32'h40; bus.mem_wdata = 32'h2;
    bus.mem_r_enable = 1'b1; bus.mem_w_enable = 1'b1;
    exp_q.push_back(32'h1);
    @(negedge clk);
    bus_idle();
    got = bus.mem_rdata; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL rw_same_old got=%h exp=%h", got, e); end
    exp_q.push_back(32'h2);
    bus_rd(32'h40, got); e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL rw_same_new got=%h exp=%h", got, e); end
  endtask

  task automatic test_uart_frame;
    logic [31:0] got, e;
    logic [8:0]  r, x;
    logic        bits[40];
    logic [7:0]  byt;
    int          n;
    byt = 8'h55;
    for (int i = 0; i < 40; i++) begin
      if (i < CPB)           bits[i] = 1'b0;
      else if (i >= 9*CPB)   bits[i] = 1'b1;
      else                   bits[i] = byt[(i - CPB) / CPB];
    end
    exp_tx_q.push_back({1'b1, byt});
    bus_wr(TXD, {24'h0, byt});
    checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL tx_before_start got=%b exp=1", uart_tx); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++; if (uart_tx !== bits[i]) begin failures++; $display("FAIL tx_cycle%0d got=%b exp=%b", i, uart_tx, bits[i]); end
      if (i == 19) begin
        bus.mem_addr = STA; bus.mem_r_enable = 1'b1;
        exp_q.push_back(32'h0C);
      end
      if (i == 20) begin
        bus_idle();
        e = exp_q.pop_front();
        checks++; if (bus.mem_rdata !== e) begin failures++; $display("FAIL status_busy got=%h exp=%h", bus.mem_rdata, e); end
      end
    end
    @(negedge clk);
    checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL tx_idle_after got=%b exp=1", uart_tx); end
    n = 0;
    while (rx_q.size() < 1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (rx_q.size() < 1) begin failures++; $display("FAIL rx_frame_timeout got=%0d exp=1", rx_q.size()); end
    else begin
      r = rx_q.pop_front(); x = exp_tx_q.pop_front();
      if (r !== x) begin failures++; $display("FAIL rx_frame got=%h exp=%h", r, x); end
    end
    exp_q.push_back(32'h04);
    bus_rd(STA, got); e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL status_after_frame got=%h exp=%h", got, e); end
  endtask

  task automatic test_fifo_overflow;
    logic [31:0] got, e;
    logic [8:0]  r, x;
    int          n;
    for (int b = 8'h41; b <= 8'h4A; b++) begin
      bus_wr(TXD, 32'(b));
      if (b <= 8'h49) exp_tx_q.push_back({1'b1, 8'(b)});
    end
    exp_q.push_back(32'h1A);
    bus_rd(STA, got); e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL status_overflow got=%h exp=%h", got, e); end
    exp_q.push_back(32'h0A);
    bus_rd(STA, got); e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL status_ovf_cleared got=%h exp=%h", got, e); end
    n = 0;
    while (rx_q.size() < 9 && n < 800) begin @(negedge clk); n++; end
    checks++;
    if (rx_q.size() != 9) begin failures++; $display("FAIL rx_count got=%0d exp=9", rx_q.size()); end
    while (rx_q.size() > 0 && exp_tx_q.size() > 0) begin
      r = rx_q.pop_front(); x = exp_tx_q.pop_front();
      checks++; if (r !== x) begin failures++; $display("FAIL rx_byte got=%h exp=%h", r, x); end
    end
    repeat (4) @(negedge clk);
    exp_q.push_back(32'h04);
    bus_rd(STA, got); e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL status_drained got=%h exp=%h", got, e); end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] got, e;
    int          lows;
    bus_wr(32'h80, 32'hCAFE_F00D);
    bus_wr(TXD, 32'h0);
    repeat (12) @(negedge clk);
    checks++; if (uart_tx !== 1'b0) begin failures++; $display("FAIL tx_mid_data got=%b exp=0", uart_tx); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL async_reset_tx got=%b exp=1", uart_tx); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_rdata !== 32'h0) begin failures++; $display("FAIL reset_clears_rdata got=%h exp=0", bus.mem_rdata); end
    exp_q.push_back(32'h04);
    bus_rd(STA, got); e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL status_after_reset got=%h exp=%h", got, e); end
    exp_q.push_back(32'hCAFE_F00D);
    bus_rd(32'h80, got); e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL ram_kept got=%h exp=%h", got, e); end
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    checks++; if (lows !== 0) begin failures++; $display("FAIL tx_quiet_after_reset got=%0d exp=0", lows); end
    rx_q.delete();
  endtask

  initial begin
    test_reset();
    test_ram();
    test_unmapped();
    test_rw_same();
    test_uart_frame();
    test_fifo_overflow();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
